// File: rtl/risc_mgmt_decode_pkg.sv
// Shared types and helpers for the decode-stage extension arbiter.
// Holds the arbitration-mode and FSM-state enums plus a multi-claim detector.
package risc_mgmt_decode_pkg;

  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    TOUT   = 2'd2
  } dec_arb_state_t;

  localparam int MAX_EXT = 16;
  localparam int CNT_W   = 8;

  // True when more than one bit of the (zero-extended) claim vector is set.
  function automatic logic multi_hot(input logic [MAX_EXT-1:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/risc_mgmt_decode_arbiter_rr_priority_arbiter.sv
// Rotating-priority winner search: first request at or after ptr, modulo N.
// A fixed-priority search is obtained by tying ptr to zero.
module rr_priority_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan all N positions starting at ptr and latch the first hit.
  always_comb begin : p_search
    int   cand_s;
    logic hit_s;
    gnt    = {N{1'b0}};
    idx    = {IDX_W{1'b0}};
    valid  = 1'b0;
    cand_s = 0;
    hit_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s = int'(ptr) + i;
      cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
      hit_s  = ~valid & req[cand_s];
      gnt[cand_s] = gnt[cand_s] | hit_s;
      idx    = hit_s ? IDX_W'(cand_s) : idx;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/risc_mgmt_decode_arbiter.sv
// Decode-stage arbiter between custom-instruction extensions: grants one
// claimant, routes its register selects and bounds its pipeline stall.
import risc_mgmt_decode_pkg::*;

module risc_mgmt_decode_arbiter #(
  parameter int        N_EXT      = 4,
  parameter int        REG_W      = 5,
  parameter arb_mode_t ARB_MODE   = FIXED,
  parameter int        MAX_BUBBLE = 15,
  localparam int       IDX_W      = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   insn_valid,
  input  logic [N_EXT-1:0]       ext_claim,
  input  logic [N_EXT-1:0]       ext_bubble_req,
  input  logic [N_EXT*REG_W-1:0] ext_rsel_s_0,
  input  logic [N_EXT*REG_W-1:0] ext_rsel_s_1,
  input  logic [N_EXT*REG_W-1:0] ext_rsel_d,
  input  logic                   err_clr,
  output logic                   insn_claim,
  output logic                   bubble_req,
  output logic [REG_W-1:0]       rsel_s_0,
  output logic [REG_W-1:0]       rsel_s_1,
  output logic [REG_W-1:0]       rsel_d,
  output logic [N_EXT-1:0]       grant,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   multi_claim_err,
  output logic                   timeout_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BUBBLE - 1);
  localparam logic [N_EXT-1:0] ONE_HOT0 = {{(N_EXT-1){1'b0}}, 1'b1};

  dec_arb_state_t   state_r, state_nxt_s;
  logic [IDX_W-1:0] lock_id_r, lock_id_nxt_s;
  logic [CNT_W-1:0] bub_cnt_r, bub_cnt_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic             multi_claim_err_r;
  logic             timeout_err_r;

  logic [N_EXT-1:0] arb_req_s;
  logic [IDX_W-1:0] arb_ptr_s;
  logic [N_EXT-1:0] arb_gnt_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             arb_valid_s;
  logic [IDX_W-1:0] sel_id_s;
  logic             sel_en_s;
  logic             mce_set_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_EXT - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return i + IDX_W'(1);
    end
  endfunction

  assign arb_req_s = insn_valid ? ext_claim : {N_EXT{1'b0}};
  assign arb_ptr_s = (ARB_MODE == RR) ? rr_ptr_r : {IDX_W{1'b0}};

  rr_priority_arbiter #(
    .N     (N_EXT),
    .IDX_W (IDX_W)
  ) u_search (
    .req   (arb_req_s),
    .ptr   (arb_ptr_s),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Multi-claim is only meaningful when the arbiter is actually choosing.
  assign mce_set_s = (state_r == IDLE) & insn_valid & multi_hot(MAX_EXT'(ext_claim));

  // Next-state and combinational grant outputs.
  always_comb begin
    state_nxt_s   = state_r;
    lock_id_nxt_s = lock_id_r;
    bub_cnt_nxt_s = bub_cnt_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    insn_claim    = 1'b0;
    bubble_req    = 1'b0;
    grant         = {N_EXT{1'b0}};
    grant_id      = {IDX_W{1'b0}};
    sel_id_s      = {IDX_W{1'b0}};
    sel_en_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          insn_claim = 1'b1;
          grant      = arb_gnt_s;
          grant_id   = arb_idx_s;
          sel_id_s   = arb_idx_s;
          sel_en_s   = 1'b1;
          bubble_req = ext_bubble_req[arb_idx_s];
          if (ext_bubble_req[arb_idx_s]) begin
            state_nxt_s   = (MAX_BUBBLE == 1) ? TOUT : LOCKED;
            lock_id_nxt_s = arb_idx_s;
            bub_cnt_nxt_s = 8'd1;
          end else begin
            rr_ptr_nxt_s = wrap_inc(arb_idx_s);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        insn_claim = 1'b1;
        grant      = ONE_HOT0 << lock_id_r;
        grant_id   = lock_id_r;
        sel_id_s   = lock_id_r;
        sel_en_s   = 1'b1;
        bubble_req = ext_bubble_req[lock_id_r];
        // A released stall ends the grant; it does not count as a bubble.
        if (!ext_bubble_req[lock_id_r]) begin
          state_nxt_s   = IDLE;
          bub_cnt_nxt_s = 8'd0;
          rr_ptr_nxt_s  = wrap_inc(lock_id_r);
        end else if (bub_cnt_r < LAST_CNT) begin
          bub_cnt_nxt_s = bub_cnt_r + 8'd1;
        end else begin
          state_nxt_s = TOUT;
        end
      end
      TOUT: begin
        insn_claim    = 1'b1;
        grant         = ONE_HOT0 << lock_id_r;
        grant_id      = lock_id_r;
        sel_id_s      = lock_id_r;
        sel_en_s      = 1'b1;
        bubble_req    = 1'b0;
        state_nxt_s   = IDLE;
        bub_cnt_nxt_s = 8'd0;
        rr_ptr_nxt_s  = wrap_inc(lock_id_r);
      end
      default: begin
        state_nxt_s   = IDLE;
        bub_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Register-select routing from the current owner.
  always_comb begin
    if (sel_en_s) begin
      rsel_s_0 = ext_rsel_s_0[sel_id_s*REG_W +: REG_W];
      rsel_s_1 = ext_rsel_s_1[sel_id_s*REG_W +: REG_W];
      rsel_d   = ext_rsel_d[sel_id_s*REG_W +: REG_W];
    end else begin
      rsel_s_0 = {REG_W{1'b0}};
      rsel_s_1 = {REG_W{1'b0}};
      rsel_d   = {REG_W{1'b0}};
    end
  end

  // State, pointer and error-flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r           <= IDLE;
      lock_id_r         <= {IDX_W{1'b0}};
      bub_cnt_r         <= 8'd0;
      rr_ptr_r          <= {IDX_W{1'b0}};
      multi_claim_err_r <= 1'b0;
      timeout_err_r     <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      lock_id_r         <= lock_id_nxt_s;
      bub_cnt_r         <= bub_cnt_nxt_s;
      rr_ptr_r          <= rr_ptr_nxt_s;
      // Set dominates clear so a fresh violation is never lost.
      multi_claim_err_r <= mce_set_s | (multi_claim_err_r & ~err_clr);
      timeout_err_r     <= (state_nxt_s == TOUT);
    end
  end

  assign multi_claim_err = multi_claim_err_r;
  assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_risc_mgmt_decode_arbiter.sv
// Scoreboard bench: two instances (FIXED/MAX_BUBBLE=15 and RR/MAX_BUBBLE=4),
// directed per-cycle vectors with hand-computed expected output bundles.
module tb_risc_mgmt_decode_arbiter;

  typedef struct {
    string       name;
    bit          which;
    logic [24:0] v;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        err_clr = 1'b0;
  logic [19:0] rs0, rs1, rd;

  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_claim = 4'b0, b_claim = 4'b0, a_bub = 4'b0, b_bub = 4'b0;
  logic        a_ic, a_br, a_mce, a_to, b_ic, b_br, b_mce, b_to;
  logic [3:0]  a_gnt, b_gnt;
  logic [1:0]  a_gid, b_gid;
  logic [4:0]  a_s0, a_s1, a_d, b_s0, b_s1, b_d;

  exp_t        q[$];
  exp_t        cur;
  logic [24:0] act;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 CLK = ~CLK;

  risc_mgmt_decode_arbiter u_a (
    .CLK(CLK), .RST(RST), .insn_valid(a_valid), .ext_claim(a_claim),
    .ext_bubble_req(a_bub), .ext_rsel_s_0(rs0), .ext_rsel_s_1(rs1),
    .ext_rsel_d(rd), .err_clr(err_clr), .insn_claim(a_ic), .bubble_req(a_br),
    .rsel_s_0(a_s0), .rsel_s_1(a_s1), .rsel_d(a_d), .grant(a_gnt),
    .grant_id(a_gid), .multi_claim_err(a_mce), .timeout_err(a_to)
  );

  risc_mgmt_decode_arbiter #(
    .ARB_MODE(risc_mgmt_decode_pkg::RR), .MAX_BUBBLE(4)
  ) u_b (
    .CLK(CLK), .RST(RST), .insn_valid(b_valid), .ext_claim(b_claim),
    .ext_bubble_req(b_bub), .ext_rsel_s_0(rs0), .ext_rsel_s_1(rs1),
    .ext_rsel_d(rd), .err_clr(err_clr), .insn_claim(b_ic), .bubble_req(b_br),
    .rsel_s_0(b_s0), .rsel_s_1(b_s1), .rsel_d(b_d), .grant(b_gnt),
    .grant_id(b_gid), .multi_claim_err(b_mce), .timeout_err(b_to)
  );

  // Expected bundle {claim, bubble, grant, id, s0, s1, d, mce, tout}.
  function automatic logic [24:0] ev(input bit g, input int id, input bit bub,
                                     input bit mce, input bit tout);
    logic [3:0]  one;
    logic [24:0] r;
    one = 4'b0001 << id;
    if (g) r = {1'b1, bub, one, 2'(id), 5'(id + 1), 5'(id + 10), 5'(id + 20), mce, tout};
    else   r = {1'b0, 1'b0, 4'b0000, 2'b00, 15'd0, mce, tout};
    return r;
  endfunction

  function automatic string fmt(input logic [24:0] v);
    return $sformatf("claim=%0b bub=%0b grant=%b id=%0d s0=%0d s1=%0d d=%0d mce=%0b tout=%0b",
                     v[24], v[23], v[22:19], v[18:17], v[16:12], v[11:7], v[6:2], v[1], v[0]);
  endfunction

  task automatic cyc(input string nm, input bit w, input bit rst, input bit clr,
                     input bit v, input logic [3:0] c, input logic [3:0] b,
                     input logic [24:0] e);
    exp_t x;
    @(posedge CLK); #1;
    RST = rst; err_clr = clr;
    a_valid = w ? 1'b0 : v;  a_claim = w ? 4'b0 : c;  a_bub = w ? 4'b0 : b;
    b_valid = w ? v : 1'b0;  b_claim = w ? c : 4'b0;  b_bub = w ? b : 4'b0;
    x.name = nm; x.which = w; x.v = e;
    q.push_back(x);
  endtask

  // Monitor: pop one expectation per cycle and compare the selected instance.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      act = cur.which ? {b_ic, b_br, b_gnt, b_gid, b_s0, b_s1, b_d, b_mce, b_to}
                      : {a_ic, a_br, a_gnt, a_gid, a_s0, a_s1, a_d, a_mce, a_to};
      n_checks++;
      if (act === cur.v) n_pass++;
      else $display("FAIL %s: actual %s required %s", cur.name, fmt(act), fmt(cur.v));
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rs0[i*5 +: 5] = 5'(i + 1);
      rs1[i*5 +: 5] = 5'(i + 10);
      rd[i*5 +: 5]  = 5'(i + 20);
    end
    repeat (2) @(posedge CLK);
    #1;
    // Instance A: FIXED priority, MAX_BUBBLE=15
    cyc("a_reset_state",   0, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 0, 0));
    cyc("a_fixed_0110",    0, 0, 0, 1, 4'b0110, 4'b0000, ev(1, 1, 0, 0, 0));
    cyc("a_mce_set",       0, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 1, 0));
    cyc("a_clr_cycle",     0, 0, 1, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 1, 0));
    cyc("a_mce_cleared",   0, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 0, 0));
    cyc("a_novalid_claim", 0, 0, 0, 0, 4'b1111, 4'b0000, ev(0, 0, 0, 0, 0));
    cyc("a_fixed_1000",    0, 0, 0, 1, 4'b1000, 4'b0000, ev(1, 3, 0, 0, 0));
    cyc("a_fixed_0011",    0, 0, 0, 1, 4'b0011, 4'b0000, ev(1, 0, 0, 0, 0));
    cyc("a_clr_and_set",   0, 0, 1, 1, 4'b0101, 4'b0000, ev(1, 0, 0, 1, 0));
    cyc("a_set_wins",      0, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 1, 0));
    cyc("a_clr2",          0, 0, 1, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 1, 0));
    cyc("a_mce_cleared2",  0, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 0, 0));
    cyc("a_lock_bub1",     0, 0, 0, 1, 4'b1000, 4'b1000, ev(1, 3, 1, 0, 0));
    cyc("a_lock_bub2",     0, 0, 0, 1, 4'b1001, 4'b1001, ev(1, 3, 1, 0, 0));
    cyc("a_lock_bub3",     0, 0, 0, 1, 4'b1001, 4'b1000, ev(1, 3, 1, 0, 0));
    cyc("a_lock_release",  0, 0, 0, 1, 4'b0001, 4'b0001, ev(1, 3, 0, 0, 0));
    cyc("a_idle_again",    0, 0, 0, 1, 4'b0001, 4'b0000, ev(1, 0, 0, 0, 0));
    cyc("a_bub_isolation", 0, 0, 0, 1, 4'b0010, 4'b0001, ev(1, 1, 0, 0, 0));
    // Instance B: round-robin, MAX_BUBBLE=4
    cyc("b_rr_1",          1, 0, 0, 1, 4'b0101, 4'b0000, ev(1, 0, 0, 0, 0));
    cyc("b_rr_2",          1, 0, 0, 1, 4'b0101, 4'b0000, ev(1, 2, 0, 1, 0));
    cyc("b_rr_3",          1, 0, 0, 1, 4'b0101, 4'b0000, ev(1, 0, 0, 1, 0));
    cyc("b_rr_4",          1, 0, 0, 1, 4'b0101, 4'b0000, ev(1, 2, 0, 1, 0));
    cyc("b_clr",           1, 0, 1, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 1, 0));
    cyc("b_mce_cleared",   1, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 0, 0));
    cyc("b_tout_bub1",     1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_tout_bub2",     1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_tout_bub3",     1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_tout_bub4",     1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_tout_cycle",    1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 0, 0, 1));
    cyc("b_after_tout",    1, 0, 0, 0, 4'b0000, 4'b0010, ev(0, 0, 0, 0, 0));
    cyc("b_lock_c0",       1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_lock_c1",       1, 0, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_lock_c2_rst",   1, 1, 0, 1, 4'b0010, 4'b0010, ev(1, 1, 1, 0, 0));
    cyc("b_post_reset",    1, 0, 0, 0, 4'b0000, 4'b0000, ev(0, 0, 0, 0, 0));
    cyc("b_ptr_zero",      1, 0, 0, 1, 4'b0110, 4'b0000, ev(1, 1, 0, 0, 0));
    cyc("b_single_1",      1, 0, 0, 1, 4'b0010, 4'b0000, ev(1, 1, 0, 1, 0));
    @(posedge CLK); #1;
    a_valid = 1'b0; b_valid = 1'b0; a_claim = 4'b0; b_claim = 4'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: actual %0d pending required 0 pending", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_mgmt_decode_arbiter.md
RISC_MGMT_DECODE_ARBITER -- requirements
Module: risc_mgmt_decode_arbiter

Interface
REQ-001 Parameters SHALL be: N_EXT, 4, number of decode-stage extensions (2..16).
REQ-002 Parameters SHALL be: REG_W, 5, register-select width (4 for RV32E).
REQ-003 Parameters SHALL be: ARB_MODE, FIXED, arbitration mode, either FIXED (lowest index wins) or RR (round-robin).
REQ-004 Parameters SHALL be: MAX_BUBBLE, 15, maximum consecutive bubble_req cycles per grant (1..255).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port: CLK  in  1  clock, all state on rising edge.
REQ-007 Port: RST  in  1  synchronous active-high reset.
REQ-008 Port: insn_valid  in  1  decode stage holds a valid instruction.
REQ-009 Port: ext_claim  in  N_EXT  per-extension claim of the current instruction.
REQ-010 Port: ext_bubble_req  in  N_EXT  per-extension stall request.
REQ-011 Port: ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d  in  N_EXT*REG_W each  packed per-extension register selects, extension i at bits [i*REG_W +: REG_W].
REQ-012 Port: err_clr  in  1  clears multi_claim_err.
REQ-013 Port: insn_claim  out  1  instruction owned by an extension.
REQ-014 Port: bubble_req  out  1  stall request to the pipeline.
REQ-015 Port: rsel_s_0, rsel_s_1, rsel_d  out  REG_W each  winner's register selects.
REQ-016 Port: grant  out  N_EXT  one-hot winner.
REQ-017 Port: grant_id  out  max(1,$clog2(N_EXT))  winner index.
REQ-018 Port: multi_claim_err  out  1  sticky, more than one claim in an arbitrated cycle.
REQ-019 Port: timeout_err  out  1  one-cycle pulse on bubble timeout.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, LOCKED and TOUT.
REQ-021 In IDLE with insn_valid=1 and any ext_claim set, the winner SHALL be granted combinationally in the same cycle: insn_claim=1, grant/grant_id/rsel_* taken from the winner, and bubble_req=ext_bubble_req[winner].
REQ-022 In IDLE with insn_valid=0 or no claim, insn_claim, bubble_req, grant and rsel_* SHALL all be 0.
REQ-023 In FIXED mode, the lowest claiming index SHALL win.
REQ-024 In RR mode, the first claiming index at or after rr_ptr (modulo N_EXT) SHALL win.
REQ-025 In IDLE, a granted winner with bubble_req=1 SHALL cause a transition to LOCKED with lock_id=winner and bub_cnt=1; if MAX_BUBBLE=1, the transition SHALL go to TOUT instead.
REQ-026 In LOCKED, the grant SHALL be held on lock_id regardless of insn_valid or other claims.
REQ-027 In LOCKED, insn_claim SHALL be 1 and bubble_req SHALL equal ext_bubble_req[lock_id].
REQ-028 In LOCKED, ext_bubble_req[lock_id]=0 SHALL cause a transition to IDLE in the next cycle; that cycle SHALL not itself count as a bubble.
REQ-029 In LOCKED, bubble_req=1 with bub_cnt<MAX_BUBBLE-1 SHALL increment bub_cnt; with bub_cnt=MAX_BUBBLE-1 it SHALL cause a transition to TOUT.
REQ-030 TOUT SHALL last one cycle with grant held, insn_claim=1, bubble_req forced to 0 and timeout_err=1, followed by a transition to IDLE.
REQ-031 The bubble_req output SHALL never be 1 for more than MAX_BUBBLE consecutive cycles.
REQ-032 rr_ptr SHALL update to (winner+1) mod N_EXT on every completed grant: an IDLE grant without a bubble, a LOCKED-to-IDLE transition, or TOUT; rr_ptr SHALL be unused in FIXED mode.
REQ-033 multi_claim_err SHALL set on any IDLE cycle with insn_valid=1 and popcount(ext_claim)>1, and SHALL be cleared by err_clr; set SHALL win if both occur in the same cycle.
REQ-034 Claims in LOCKED and TOUT SHALL be ignored for multi_claim_err.
REQ-035 ext_bubble_req from a non-winner SHALL never reach bubble_req.

Reset
REQ-036 RST=1 at a clock edge SHALL force state=IDLE, lock_id=0, bub_cnt=0, rr_ptr=0, multi_claim_err=0 and timeout_err=0, overriding all other inputs.
REQ-037 A reset asserted while LOCKED or in TOUT SHALL drop the grant; the block SHALL then re-arbitrate from index 0 on the first cycle after reset.

Structure
REQ-038 Package risc_mgmt_decode_pkg SHALL hold the arb_mode_t enum (FIXED, RR) and the dec_arb_state_t enum (IDLE, LOCKED, TOUT).
REQ-039 The winner search SHALL be a sub-module rr_priority_arbiter (inputs: request vector and start pointer; outputs: one-hot grant, index, valid), with FIXED mode implemented by tying the pointer to 0.
REQ-040 No output SHALL be registered other than timeout_err and multi_claim_err.

Verification
REQ-041 FIXED, N_EXT=4: ext_claim=4'b0110, bubble_req=0, insn_valid=1 -> grant=4'b0010, grant_id=1, rsel_* from extension 1, multi_claim_err=1 next cycle.
REQ-042 RR mode: extensions 0 and 2 claim without bubbles for 4 cycles -> grant_id sequence 0, 2, 0, 2.
REQ-043 Extension 3 claims with bubble_req for 3 cycles while extension 0 claims -> bubble_req=1 for 3 cycles, grant held at 3, IDLE re-entered on cycle 4.
REQ-044 MAX_BUBBLE=4 with bubble_req held indefinitely -> bubble_req=1 for exactly 4 cycles, then one TOUT cycle with timeout_err=1 and bubble_req=0, then IDLE.
REQ-045 RST=1 during LOCKED cycle 2 -> all outputs 0 on the next cycle; rr_ptr=0; a subsequent claim from extension 1 alone yields grant_id=1.
REQ-046 err_clr=1 and a new multi-claim in the same cycle -> multi_claim_err stays 1.
